mem_bist_ctrl: RTL
==================

Name: mem_bist_ctrl

Overview:
Self-running built-in self-test initiator for the word memory block. It drives the memory's write/read port (WrEn, RdEn, RdEn_Opcode, Addr, WrBus) and consumes RdBus. It writes an address-derived pattern to every location, reads each location back, and compares the result. It reports error count, first failing address and pass/fail, and sits beside the memory in place of the hand-written write/read loop used at bring-up.

Parameters:
ADDR_W, 8, memory address width.
DATA_W, 32, memory data width.
DEPTH, 256, locations tested, addresses 0..DEPTH-1; must be 1..2^ADDR_W.
RD_LATENCY, 2, cycles RdEn/Addr are held before RdBus is valid; must be >=1.
PATTERN_SEED, 32'h0000_0000, XOR mask applied to the write pattern.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse that begins a test; sampled only in IDLE.
busy  output  1  high from the cycle after start is accepted until DONE is entered.
done  output  1  level, high in DONE state.
pass  output  1  done && (err_count==0).
err_count  output  ADDR_W+2  number of mismatches, saturating.
first_fail_addr  output  ADDR_W  address of the first mismatch; 0 if none.
WrEn  output  1  memory write enable.
RdEn  output  1  memory read enable.
RdEn_Opcode  output  2  memory read opcode; always 2'b00 (full-word read).
Addr  output  ADDR_W  memory address.
WrBus  output  DATA_W  memory write data.
RdBus  input  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous): state=IDLE; busy, done, pass, WrEn, RdEn = 0; RdEn_Opcode, Addr, WrBus, err_count, first_fail_addr = 0.
- Pattern for address a: P(a) = zero-extend(a) to DATA_W, XOR PATTERN_SEED. With the default seed, WrBus equals the address.
- States:
  - IDLE: on start=1, go to WRITE. Clear err_count and first_fail_addr. Set the address counter to 0.
  - WRITE: each cycle drive WrEn=1, RdEn=0, Addr=a, WrBus=P(a), then a++. When a==DEPTH-1 has been written, go to READ with a=0. This takes exactly DEPTH cycles.
  - READ: hold RdEn=1, WrEn=0, Addr=a for RD_LATENCY consecutive cycles. On the clock edge ending that window, compare RdBus with P(a).
    - On mismatch, increment err_count (saturating at all ones). If this is the first error, latch first_fail_addr=a.
    - Then a++. After a==DEPTH-1 is checked, go to DONE.
    - This takes DEPTH*RD_LATENCY cycles.
  - DONE: WrEn=RdEn=0; Addr and WrBus return to 0; done=1; busy=0; results held. On start=1, behave as in IDLE (restart).
- busy is high for exactly DEPTH + DEPTH*RD_LATENCY cycles per test (768 with defaults).
- start while busy is ignored: no restart, no counter effect.
- WrEn and RdEn are never high in the same cycle.
- RdBus is ignored outside the compare edge.
- Reset mid-test aborts immediately: all outputs go to their reset values and no partial results are kept.
- DEPTH=1 is legal: one write, one read window, then DONE.

Optional Feature:
MEM_BIST_INVERT_PASS_EN.
- Defined: after the first READ phase completes, run a second WRITE+READ pass using ~P(a). err_count and first_fail_addr accumulate across both passes, and first_fail_addr keeps the earliest failure in time. busy lasts 2*(DEPTH + DEPTH*RD_LATENCY) cycles.
- Undefined: single pass only; no inverted-pattern logic is synthesised.

Test Plan:
1. Defaults with an ideal memory model (latency 2): reset, then start pulse.
   - Expect 256 WrEn cycles with Addr/WrBus = 0..255, then 512 RdEn cycles.
   - busy high for 768 cycles; done=1, pass=1, err_count=0, first_fail_addr=0.
2. Model forces bit 3 of the read at Addr=8'h10 (returns 32'h18):
   - Expect err_count=1, first_fail_addr=8'h10, pass=0.
3. Model returns 32'hFFFF_FFFF for every read:
   - Expect err_count=256, first_fail_addr=8'h00, pass=0.
4. Start pulses at busy cycles 5 and 400:
   - Expect both ignored; busy still exactly 768 cycles; results as in test 1.
5. Reset asserted asynchronously mid-clock while Addr=8'h40 in READ:
   - Expect all outputs 0 before the next edge and state IDLE.
   - A following start completes with pass=1.
6. With MEM_BIST_INVERT_PASS_EN defined, model corrupts only the read returning ~32'h05 at Addr=8'h05:
   - Expect busy=1536 cycles, err_count=1, first_fail_addr=8'h05.
   - Without the macro, the same model gives pass=1.

Source files
------------

// File: rtl/mem_bist_ctrl_if.sv
// Memory-side port bundle of the BIST controller: write/read strobes, address,
// write data and returned read data. The controller uses master; a memory model or wrapper uses slave.
interface mem_bist_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              WrEn;
    logic              RdEn;
    logic [1:0]        RdEn_Opcode;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WrBus;
    logic [DATA_W-1:0] RdBus;

    modport master (
        output WrEn,
        output RdEn,
        output RdEn_Opcode,
        output Addr,
        output WrBus,
        input  RdBus
    );

    modport slave (
        input  WrEn,
        input  RdEn,
        input  RdEn_Opcode,
        input  Addr,
        input  WrBus,
        output RdBus
    );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Self-running write/read-back BIST for the word memory.
// Define MEM_BIST_INVERT_PASS_EN to add a second pass that uses the inverted pattern.
module mem_bist_ctrl #(
    parameter int              ADDR_W       = 8,
    parameter int              DATA_W       = 32,
    parameter int              DEPTH        = 256,
    parameter int              RD_LATENCY   = 2,
    parameter logic [DATA_W-1:0] PATTERN_SEED = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    mem_bist_ctrl_if.master   mem
);

    localparam int              LAT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [LAT_W-1:0]   lat_reg, lat_next;
    logic [ADDR_W+1:0]  err_reg, err_next;
    logic [ADDR_W-1:0]  ffa_reg, ffa_next;
    logic               inv;
    logic [DATA_W-1:0]  pattern;

`ifdef MEM_BIST_INVERT_PASS_EN
    logic inv_reg, inv_next;
    assign inv = inv_reg;
`else
    assign inv = 1'b0;
`endif

    // Pattern for the current address; the inverted pass flips every bit.
    assign pattern = (DATA_W'(addr_reg) ^ PATTERN_SEED) ^ {DATA_W{inv}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            lat_reg   <= '0;
            err_reg   <= '0;
            ffa_reg   <= '0;
`ifdef MEM_BIST_INVERT_PASS_EN
            inv_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            lat_reg   <= lat_next;
            err_reg   <= err_next;
            ffa_reg   <= ffa_next;
`ifdef MEM_BIST_INVERT_PASS_EN
            inv_reg   <= inv_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        lat_next   = lat_reg;
        err_next   = err_reg;
        ffa_next   = ffa_reg;
`ifdef MEM_BIST_INVERT_PASS_EN
        inv_next   = inv_reg;
`endif
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_WRITE;
                    addr_next  = '0;
                    lat_next   = '0;
                    err_next   = '0;
                    ffa_next   = '0;
`ifdef MEM_BIST_INVERT_PASS_EN
                    inv_next   = 1'b0;
`endif
                end
            end
            S_WRITE: begin
                if (addr_reg == ADDR_LAST) begin
                    state_next = S_READ;
                    addr_next  = '0;
                    lat_next   = '0;
                end else begin
                    addr_next = addr_reg + ADDR_W'(1);
                end
            end
            S_READ: begin
                if (lat_reg == LAT_LAST) begin
                    // Last cycle of the hold window: RdBus is valid on this edge.
                    lat_next = '0;
                    if (mem.RdBus != pattern) begin
                        if (err_reg == '0) begin
                            ffa_next = addr_reg;
                        end
                        if (err_reg != '1) begin
                            err_next = err_reg + (ADDR_W+2)'(1);
                        end
                    end
                    if (addr_reg == ADDR_LAST) begin
                        addr_next = '0;
`ifdef MEM_BIST_INVERT_PASS_EN
                        if (!inv_reg) begin
                            inv_next   = 1'b1;
                            state_next = S_WRITE;
                        end else begin
                            state_next = S_DONE;
                        end
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        addr_next = addr_reg + ADDR_W'(1);
                    end
                end else begin
                    lat_next = lat_reg + LAT_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decode straight from registers so an asynchronous reset clears them at once.
    assign busy            = (state_reg == S_WRITE) || (state_reg == S_READ);
    assign done            = (state_reg == S_DONE);
    assign pass            = done && (err_reg == '0);
    assign err_count       = err_reg;
    assign first_fail_addr = ffa_reg;

    assign mem.WrEn        = (state_reg == S_WRITE);
    assign mem.RdEn        = (state_reg == S_READ);
    assign mem.RdEn_Opcode = 2'b00;
    assign mem.Addr        = busy ? addr_reg : '0;
    assign mem.WrBus       = (state_reg == S_WRITE) ? pattern : '0;

endmodule
